ibex_fetch_align_fifo: RTL
==========================

// Module: ibex_fetch_align_fifo
// PURPOSE
//  Instruction prefetch FIFO plus halfword aligner in the IF stage, directly upstream of ibex_controller/ID.
//  Buffers 32-bit fetch beats from the instruction bus.
//  Presents one aligned instruction per handshake: 16-bit compressed or 32-bit, possibly straddling two words.
//  Each instruction carries its PC and an error flag that feed instr_valid_i/pc_id_i/instr_fetch_err_i downstream.
//  Flushed by the controller's pc_set_o through clear_i.
// PARAMETERS
//  DEPTH  3  number of 32-bit word entries; legal range 3..8
// PORTS
//  clk_i         in   1   clock, rising edge
//  rst_ni        in   1   asynchronous reset, active low
//  clear_i       in   1   flush all entries, load in_addr_i as next PC
//  in_addr_i     in   32  new fetch PC; sampled only when clear_i=1
//  in_valid_i    in   1   fetch beat valid
//  in_rdata_i    in   32  fetch beat data
//  in_err_i      in   1   bus error on this beat
//  busy_o        out  1   count >= DEPTH-2; prefetcher issues no new request
//  out_valid_o   out  1   instruction available
//  out_ready_i   in   1   consumer accepts; transfer = out_valid_o & out_ready_i
//  out_addr_o    out  32  PC of presented instruction
//  out_rdata_o   out  32  instruction; compressed ones in [15:0]
//  out_err_o     out  1   fetch error on any word the instruction uses
// BEHAVIOUR
//  Reset values
//   - count=0, all entries invalid, addr_q=0.
//   - out_valid_o=0, out_err_o=0, busy_o=0.
//   - out_addr_o=0, out_rdata_o=0.
//  Storage
//   - In-order array of {rdata,err}; entry 0 is the head; count in 0..DEPTH.
//   - Writes are registered; no bypass. A beat accepted in cycle N is visible on out in cycle N+1.
//  Compressed test
//   - An instruction is compressed when its low halfword bits [1:0] != 2'b11.
//  Aligned output (addr_q[1]=0), needs head valid
//   - out_rdata_o = head.
//   - Compressed: addr_q += 2; head is kept.
//   - 32-bit: addr_q += 4; head is popped.
//  Unaligned output (addr_q[1]=1), lower half = head[31:16]
//   - Compressed: valid with head only; out_rdata_o = {16'h0, head[31:16]}.
//     On transfer, addr_q += 2 and head is popped.
//   - 32-bit: valid only if entry 1 is also valid; out_rdata_o = {entry1[15:0], head[31:16]};
//     out_err_o = head.err | entry1.err. On transfer, addr_q += 4 and head is popped.
//     Entry 1 is retained for its upper half.
//   - Head err=1: valid with head alone, whatever the compressed bit; out_rdata_o upper half = 16'h0.
//     On transfer the head is popped, addr_q += 4 (the address value is don't-care after an error).
//  Addressing
//   - out_addr_o = addr_q.
//   - addr_q arithmetic is modulo 2^32; 32'hFFFF_FFFE + 2 wraps to 0.
//  Simultaneous events
//   - push + pop in the same cycle is legal at any count, including full.
//   - clear_i has priority: entries are invalidated, addr_q <= {in_addr_i[31:1],1'b0},
//     and any in_valid_i beat in that cycle is discarded.
//   - out_valid_o is 0 in the cycle after clear_i.
//  Overflow
//   - in_valid_i with count=DEPTH and no pop is a protocol violation.
//   - The beat is dropped and state is unchanged; an SVA assertion flags it.
//  Stalls
//   - While out_ready_i=0, out_* stay stable unless clear_i or reset intervenes.
//   - Reset asserted mid-stream returns all state to the reset values asynchronously.
// STRUCTURE
//  - Shared package ibex_pkg: COMPRESSED check as a function; DEPTH_MIN=3 localparam.
//  - No sub-module is natural: single module with storage array, count, addr_q and an output mux.
// TESTING
//  - Aligned 32-bit: clear addr=0x100; push 0x00A00093 -> next cycle valid, addr 0x100, rdata 0x00A00093;
//    ready -> addr 0x104, count 0.
//  - Two compressed in one word: push 0x45014581 -> 0x4581 @0x100, then {16'h0,0x4501} @0x102, then empty.
//  - Straddle: clear 0x102; push 0x0093xxxx, then 0x000000A0 -> valid only after 2nd beat;
//    rdata 0x00A00093, addr 0x102.
//  - Error: clear 0x202; push err=1 -> valid with one word, out_err_o=1.
//  - Full/busy at DEPTH=3: push 2 -> busy_o=1; push 3rd with ready low -> count 3;
//    push+pop in one cycle -> count stays 3.
//  - Clear collision: clear_i with in_valid_i=1 -> beat discarded, out_valid_o=0 next cycle,
//    addr = new PC; rst_ni pulled mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/ibex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ibex_pkg                                               |
// | Description : Shared types and helpers for the IF-stage fetch FIFO.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ibex_pkg;

    localparam int DEPTH_MIN = 3;
    localparam int DEPTH_MAX = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } fetch_entry_t;

    // RVC encodings use every quadrant except 2'b11.
    function automatic logic is_compressed(input logic [15:0] instr);
        return instr[1:0] != 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_fetch_align_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ibex_fetch_align_fifo                                  |
// | Description : Prefetch word FIFO with halfword instruction aligner.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ibex_fetch_align_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] in_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_addr_o,
    output logic [31:0] out_rdata_o,
    output logic        out_err_o
);

    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t [DEPTH-1:0] r_mem;
    fetch_entry_t [DEPTH-1:0] w_mem_next;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_CNT_W-1:0]       w_count_next;
    logic [c_CNT_W-1:0]       w_wr_idx;
    logic [31:0]              r_addr;
    logic [31:0]              w_addr_next;
    logic [31:0]              w_step;

    fetch_entry_t             w_head;
    logic                     w_head_valid;
    logic                     w_entry1_valid;
    logic                     w_valid;
    logic                     w_err;
    logic [31:0]              w_rdata;
    logic                     w_pop_req;
    logic                     w_transfer;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_full;
    logic                     w_unused;

    assign w_unused       = in_addr_i[0];
    assign w_head         = r_mem[0];
    assign w_head_valid   = (r_count != '0);
    assign w_entry1_valid = (r_count >= c_CNT_W'(2));
    assign w_full         = (r_count == c_CNT_W'(DEPTH));

    always_comb begin
        w_valid   = 1'b0;
        w_rdata   = w_head.rdata;
        w_err     = w_head.err;
        w_pop_req = 1'b0;
        w_step    = 32'd4;
        if (!r_addr[1]) begin
            w_valid = w_head_valid;
            if (is_compressed(w_head.rdata[15:0])) begin
                w_step = 32'd2;
            end else begin
                w_pop_req = 1'b1;
            end
        end else begin
            // The head's upper half is always consumed when unaligned.
            w_pop_req = 1'b1;
            w_rdata   = {16'h0000, w_head.rdata[31:16]};
            if (w_head.err) begin
                w_valid = w_head_valid;
            end else if (is_compressed(w_head.rdata[31:16])) begin
                w_valid = w_head_valid;
                w_step  = 32'd2;
            end else begin
                w_valid = w_entry1_valid;
                w_rdata = {r_mem[1].rdata[15:0], w_head.rdata[31:16]};
                w_err   = w_head.err | r_mem[1].err;
            end
        end
    end

    assign w_transfer = w_valid & out_ready_i & ~clear_i;
    assign w_pop      = w_transfer & w_pop_req;
    assign w_push     = in_valid_i & ~clear_i & (~w_full | w_pop);
    assign w_wr_idx   = r_count - {{(c_CNT_W-1){1'b0}}, w_pop};

    always_comb begin
        w_mem_next = w_pop ? (r_mem >> $bits(fetch_entry_t)) : r_mem;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_push && (w_wr_idx == c_CNT_W'(i))) begin
                w_mem_next[i] = '{err: in_err_i, rdata: in_rdata_i};
            end
        end
    end

    always_comb begin
        w_count_next = r_count
                     + {{(c_CNT_W-1){1'b0}}, w_push}
                     - {{(c_CNT_W-1){1'b0}}, w_pop};
        w_addr_next  = w_transfer ? (r_addr + w_step) : r_addr;
        if (clear_i) begin
            w_count_next = '0;
            w_addr_next  = {in_addr_i[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem   <= '0;
            r_count <= '0;
            r_addr  <= '0;
        end else begin
            r_mem   <= w_mem_next;
            r_count <= w_count_next;
            r_addr  <= w_addr_next;
        end
    end

    assign busy_o      = (r_count >= c_CNT_W'(DEPTH - 2));
    assign out_valid_o = w_valid;
    assign out_addr_o  = r_addr;
    assign out_rdata_o = w_valid ? w_rdata : 32'h0;
    assign out_err_o   = w_valid & w_err;

    a_depth_range : assert property (@(posedge clk_i)
        (DEPTH >= DEPTH_MIN) && (DEPTH <= DEPTH_MAX));

    // A beat offered while full and not draining is lost.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i && !clear_i && w_full && !w_pop));

endmodule
`default_nettype wire
